serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the single-bit full adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, carry held in a flip-flop between digits.
- Start/busy/done handshake; result held until the next accepted start.
- Used where area matters more than latency. Small DIGIT trades cycles for adder width.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits added per cycle (1..WIDTH). N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request; sampled only while idle
- sub  input  1  0: a+b+carry_in; 1: a+~b+1 (carry_in ignored)
- a  input  WIDTH  operand A, sampled with accepted start
- b  input  WIDTH  operand B, sampled with accepted start
- carry_in  input  1  carry into LSB when sub=0, sampled with accepted start
- busy  output  1  high while digits are being processed
- done  output  1  one-cycle pulse: result registers just updated
- sum  output  WIDTH  result, held stable until next completion
- carry_out  output  1  carry out of MSB (for sub: 1 = no borrow, a>=b unsigned)
- overflow  output  1  signed overflow: carry into MSB xor carry out of MSB

Behaviour:
- Reset: state IDLE; busy=0, done=0, sum=0, carry_out=0, overflow=0; internal operand and carry registers cleared. Reset has priority over every other input.
- FSM states: IDLE, RUN.
  - IDLE: start=1 at edge t0 latches a, b (inverted if sub), sub, and the initial carry (carry_in, or 1 if sub), sets count=0, moves to RUN.
  - IDLE: start=0 stays in IDLE.
  - RUN: each edge adds digit [count*DIGIT +: DIGIT] with the carry register, shifts the partial result in, stores the new carry, and increments count.
  - RUN: the edge processing the last digit (count=N-1) loads sum, carry_out and overflow, asserts done, and returns to IDLE.
- Latency:
  - Start accepted at edge t0 → result registers updated and done=1 after edge t0+N.
  - done is high for exactly one cycle.
  - busy is high during the N cycles after t0 and is low in the done cycle.
- Back-to-back: start=1 in the done cycle is accepted (state is IDLE). Throughput is one operation per N cycles.
- start while busy: ignored. No queuing; operands and the in-flight result are unaffected.
- Inputs a/b/sub/carry_in may change freely during RUN without effect.
- sum/carry_out/overflow change only at completion. They are never glitched with partial results.
- overflow is computed from the MSB digit: carry into bit WIDTH-1 xor carry out of bit WIDTH-1, on the effective (possibly inverted) operands.
- Reset mid-operation: abort, return to IDLE, no done pulse, outputs forced to reset values.
- count width: clog2(N), minimum 1 bit. DIGIT=WIDTH gives N=1: done one cycle after start, busy high for one cycle.
- Arithmetic is unsigned modulo 2^WIDTH; the carry bit is not folded into sum.

Decomposition:
- Package adder_pkg: FSM state encoding (IDLE=0, RUN=1) and a function computing N and the count width from WIDTH and DIGIT.
- Sub-module digit_adder: combinational DIGIT-bit ripple of full-adder cells. Inputs x, y, cin; outputs s, cout, and c_msb_in (carry into the top bit, used for overflow).
- serial_adder instantiates one digit_adder and contains the FSM, shift registers and result registers.
- Parameter check: elaboration error if WIDTH % DIGIT != 0.

Test Plan:
- WIDTH=8, DIGIT=1, sub=0, a=0x5A, b=0x33, carry_in=0 → done exactly 8 cycles after start; sum=0x8D, carry_out=0, overflow=1; busy high for those 8 cycles.
- WIDTH=8, DIGIT=1, sub=0, a=0xFF, b=0x01, carry_in=0 → sum=0x00, carry_out=1, overflow=0. Then start with a=0x7F, b=0x00, carry_in=1 in the done cycle → accepted; sum=0x80, overflow=1 after 8 more cycles.
- WIDTH=8, DIGIT=1, sub=1: a=0x10, b=0x20 → sum=0xF0, carry_out=0, overflow=0. Then a=0x80, b=0x01 → sum=0x7F, carry_out=1, overflow=1.
- Start 0x01+0x01, then pulse start with a=0xFF, b=0xFF at cycle 3 of RUN → ignored; result sum=0x02, only one done pulse.
- Reset asserted at cycle 4 of RUN → next cycle busy=0, done=0, sum=0; no done pulse follows. A fresh start after reset completes normally.
- WIDTH=8, DIGIT=4, sub=0, a=0xFF, b=0xFF, carry_in=1 → done 2 cycles after start, sum=0xFF, carry_out=1, overflow=0. Repeat with DIGIT=8 → done 1 cycle after start, same result.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and
// derived sizing helpers.
package adder_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_t;

    // Cycles per operation.
    function automatic int unsigned calc_n(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    // Width of the digit counter; never narrower than one bit.
    function automatic int unsigned calc_cw(input int unsigned width, input int unsigned digit);
        int unsigned n;
        n = width / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder built from full-adder cells.
// Also exposes the carry into the top bit so the caller can derive overflow.
module digit_adder #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    always_comb begin
        logic [DIGIT:0] c;
        c    = '0;
        c[0] = cin;
        s    = '0;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        cout     = c[DIGIT];
        c_msb_in = c[DIGIT-1];
    end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract unit: processes DIGIT bits per clock with the
// carry held in a flip-flop, start/busy/done handshake, result held until next completion.
module serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    if ((DIGIT < 1) || (DIGIT > WIDTH) || (WIDTH % DIGIT != 0)) begin : g_param_check
        $error("serial_adder: WIDTH must be a non-zero multiple of DIGIT");
    end

    localparam int unsigned N  = calc_n(WIDTH, DIGIT);
    localparam int unsigned CW = calc_cw(WIDTH, DIGIT);
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_next;
    logic             carry_q;
    logic [CW-1:0]    count_q;
    logic [IW-1:0]    idx;

    logic [DIGIT-1:0] x_dig;
    logic [DIGIT-1:0] y_dig;
    logic [DIGIT-1:0] s_dig;
    logic             cout_dig;
    logic             cmsb_dig;

    assign idx   = IW'(count_q * DIGIT);
    assign x_dig = a_q[idx +: DIGIT];
    assign y_dig = b_q[idx +: DIGIT];

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x        (x_dig),
        .y        (y_dig),
        .cin      (carry_q),
        .s        (s_dig),
        .cout     (cout_dig),
        .c_msb_in (cmsb_dig)
    );

    // Partial result with the current digit merged in; becomes sum on the last digit.
    always_comb begin
        acc_next             = acc_q;
        acc_next[idx +: DIGIT] = s_dig;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            count_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : carry_in;
                        count_q <= '0;
                        acc_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    acc_q   <= acc_next;
                    carry_q <= cout_dig;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST) begin
                        sum       <= acc_next;
                        carry_out <= cout_dig;
                        overflow  <= cout_dig ^ cmsb_dig;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at DIGIT=1, 4 and 8 (WIDTH=8) against
// an integer-arithmetic reference model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] start;
    logic       sub;
    logic       carry_in;
    logic [7:0] a;
    logic [7:0] b;

    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] co_v;
    logic [2:0] ov_v;
    logic [7:0] sum_v [0:2];

    logic [1:0] sel;
    logic       busy_m;
    logic       done_m;
    logic       co_m;
    logic       ov_m;
    logic [7:0] sum_m;

    logic [7:0] prev_sum [0:2];
    logic       prev_co  [0:2];
    logic       prev_ov  [0:2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .reset(reset), .start(start[0]), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]),
        .carry_out(co_v[0]), .overflow(ov_v[0])
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .reset(reset), .start(start[1]), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]),
        .carry_out(co_v[1]), .overflow(ov_v[1])
    );

    serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .reset(reset), .start(start[2]), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]),
        .carry_out(co_v[2]), .overflow(ov_v[2])
    );

    always_comb begin
        busy_m = busy_v[sel];
        done_m = done_v[sel];
        co_m   = co_v[sel];
        ov_m   = ov_v[sel];
        sum_m  = sum_v[sel];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int n_of(input logic [1:0] s);
        case (s)
            2'd0:    return 8;
            2'd1:    return 2;
            default: return 1;
        endcase
    endfunction

    // Reference: plain integer arithmetic, signed overflow from range check.
    task automatic model(input logic [7:0] aa, input logic [7:0] bb, input logic s,
                         input logic c, output logic [7:0] es, output logic eco,
                         output logic eov);
        int beff, cin, tot, sa, sb, sr;
        beff = s ? 255 - int'(bb) : int'(bb);
        cin  = s ? 1 : int'(c);
        tot  = int'(aa) + beff + cin;
        es   = 8'(tot);
        eco  = (tot >= 256);
        sa   = (int'(aa) >= 128) ? int'(aa) - 256 : int'(aa);
        sb   = (beff >= 128) ? beff - 256 : beff;
        sr   = sa + sb + cin;
        eov  = (sr > 127) || (sr < -128);
    endtask

    // Entered just after a negedge; leaves at the negedge of the done cycle.
    task automatic run_op(input logic [1:0] s_idx, input logic [7:0] aa, input logic [7:0] bb,
                          input logic ss, input logic cc, input int glitch_k);
        int n;
        logic [7:0] es;
        logic eco, eov;
        sel = s_idx;
        n   = n_of(s_idx);
        model(aa, bb, ss, cc, es, eco, eov);
        a        = aa;
        b        = bb;
        sub      = ss;
        carry_in = cc;
        start    = 3'b000;
        start[s_idx] = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= n; j++) begin
            @(negedge clk);
            check($sformatf("s%0d_busy_j%0d", s_idx, j), 32'(busy_m), 32'(j < n));
            check($sformatf("s%0d_done_j%0d", s_idx, j), 32'(done_m), 32'(j == n));
            if (j < n) begin
                check($sformatf("s%0d_hold_sum", s_idx), 32'(sum_m), 32'(prev_sum[s_idx]));
            end else begin
                check($sformatf("s%0d_sum", s_idx), 32'(sum_m), 32'(es));
                check($sformatf("s%0d_cout", s_idx), 32'(co_m), 32'(eco));
                check($sformatf("s%0d_ovf", s_idx), 32'(ov_m), 32'(eov));
            end
            start = 3'b000;
            if (j == glitch_k && j < n) begin
                start[s_idx] = 1'b1;
                a   = 8'hFF;
                b   = 8'hFF;
                sub = 1'b0;
            end else begin
                a        = 8'($urandom);
                b        = 8'($urandom);
                sub      = 1'($urandom);
                carry_in = 1'($urandom);
            end
        end
        prev_sum[s_idx] = es;
        prev_co[s_idx]  = eco;
        prev_ov[s_idx]  = eov;
    endtask

    task automatic idle_check();
        @(negedge clk);
        check($sformatf("s%0d_idle_done", sel), 32'(done_m), 32'(0));
        check($sformatf("s%0d_idle_busy", sel), 32'(busy_m), 32'(0));
        check($sformatf("s%0d_idle_sum", sel), 32'(sum_m), 32'(prev_sum[sel]));
        check($sformatf("s%0d_idle_cout", sel), 32'(co_m), 32'(prev_co[sel]));
    endtask

    task automatic reset_outputs_check(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_busy%0d", tag, i), 32'(busy_v[i]), 32'(0));
            check($sformatf("%s_done%0d", tag, i), 32'(done_v[i]), 32'(0));
            check($sformatf("%s_sum%0d", tag, i), 32'(sum_v[i]), 32'(0));
            check($sformatf("%s_cout%0d", tag, i), 32'(co_v[i]), 32'(0));
            check($sformatf("%s_ovf%0d", tag, i), 32'(ov_v[i]), 32'(0));
            prev_sum[i] = 8'h00;
            prev_co[i]  = 1'b0;
            prev_ov[i]  = 1'b0;
        end
    endtask

    initial begin
        int gk;
        logic [1:0] si;
        reset    = 1'b1;
        start    = 3'b000;
        sub      = 1'b0;
        carry_in = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        sel      = 2'd0;
        repeat (3) @(negedge clk);
        reset_outputs_check("rst");
        reset = 1'b0;
        @(negedge clk);

        // Directed cases, DIGIT=1.
        run_op(2'd0, 8'h5A, 8'h33, 1'b0, 1'b0, -1);
        idle_check();
        run_op(2'd0, 8'hFF, 8'h01, 1'b0, 1'b0, -1);
        run_op(2'd0, 8'h7F, 8'h00, 1'b0, 1'b1, -1);  // started in the done cycle
        idle_check();
        run_op(2'd0, 8'h10, 8'h20, 1'b1, 1'b0, -1);
        run_op(2'd0, 8'h80, 8'h01, 1'b1, 1'b0, -1);
        idle_check();
        run_op(2'd0, 8'h01, 8'h01, 1'b0, 1'b0, 3);   // start while busy is ignored
        idle_check();

        // Reset during RUN aborts with no done pulse.
        sel      = 2'd0;
        a        = 8'h01;
        b        = 8'h02;
        sub      = 1'b0;
        carry_in = 1'b0;
        start    = 3'b001;
        @(posedge clk);
        for (int j = 0; j <= 4; j++) begin
            @(negedge clk);
            start = 3'b000;
            check($sformatf("mid_busy_j%0d", j), 32'(busy_m), 32'(1));
        end
        reset = 1'b1;
        @(negedge clk);
        reset_outputs_check("midrst");
        reset = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("post_rst_done", 32'(done_m), 32'(0));
        end
        run_op(2'd0, 8'h21, 8'h42, 1'b0, 1'b1, -1);
        idle_check();

        // Wide digits.
        run_op(2'd1, 8'hFF, 8'hFF, 1'b0, 1'b1, -1);
        idle_check();
        run_op(2'd2, 8'hFF, 8'hFF, 1'b0, 1'b1, -1);
        idle_check();

        // Randomized operations on every instance.
        for (int s = 0; s < 3; s++) begin
            si = 2'(s);
            for (int i = 0; i < 20; i++) begin
                gk = -1;
                if ((n_of(si) > 1) && ($urandom_range(0, 2) == 0))
                    gk = int'($urandom_range(0, n_of(si) - 1));
                run_op(si, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), gk);
                if ($urandom_range(0, 1) == 1) idle_check();
            end
            idle_check();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
